// File: rtl/day_3_topk.sv
// Streaming K-digit top-pick solver: per bank, keeps the largest ordered K-digit subsequence,
// converts it to binary and accumulates; emits the total after tlast. Optional stats: DAY3_TOPK_STATS_EN.
module day_3_topk #(
  parameter int unsigned K           = 12,
  parameter int unsigned OUTPUTWIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [3:0]             s_axis_tdata,
  input  logic                   s_axis_tuser,
  input  logic                   s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [OUTPUTWIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tlast
`ifdef DAY3_TOPK_STATS_EN
  ,
  output logic [31:0]            bank_count,
  output logic [31:0]            short_bank_count
`endif
);

  localparam int unsigned BW = 4 * K;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONV   = 2'd1;
  localparam logic [1:0] S_OUTPUT = 2'd2;

  logic [1:0]             state;
  logic [BW-1:0]          best    [1:K];
  logic [K:1]             bval;
  logic [BW-1:0]          best_nx [1:K];
  logic [K:1]             bval_nx;
  logic [BW-1:0]          pre     [0:K-1];
  logic [K-1:0]           pv;
  logic [BW-1:0]          cand;
  logic [4:0]             len;
  logic [BW-1:0]          conv_bcd;
  logic                   conv_ok;
  logic                   conv_last;
  logic [4:0]             idx;
  logic [OUTPUTWIDTH-1:0] acc;
  logic [OUTPUTWIDTH-1:0] acc_nx;
  logic [OUTPUTWIDTH-1:0] sum;
  logic                   beat_acc;
  logic                   eob;
  logic                   dig_ok;

  assign beat_acc     = s_axis_tvalid & s_axis_tready;
  assign eob          = s_axis_tuser | s_axis_tlast;
  assign dig_ok       = (s_axis_tdata <= 4'd9);
  assign m_axis_tdata = sum;
  assign m_axis_tlast = m_axis_tvalid;
  assign acc_nx       = acc * OUTPUTWIDTH'(10) + OUTPUTWIDTH'(conv_bcd[BW-1 -: 4]);

  // Best j-digit values are right-aligned BCD, so lexicographic order equals numeric order.
  always_comb begin
    cand   = '0;
    pre[0] = '0;
    pv     = '0;
    pv[0]  = 1'b1;
    for (int unsigned j = 1; j < K; j++) begin
      pre[j] = best[j];
      pv[j]  = bval[j];
    end
    bval_nx = bval;
    for (int unsigned j = 1; j <= K; j++) begin
      best_nx[j] = best[j];
    end
    if (dig_ok) begin
      for (int unsigned j = 1; j <= K; j++) begin
        cand = (pre[j-1] << 4) | BW'(s_axis_tdata);
        if (pv[j-1] && (!bval[j] || cand > best[j])) begin
          best_nx[j] = cand;
          bval_nx[j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      sum           <= '0;
      acc           <= '0;
      conv_bcd      <= '0;
      conv_ok       <= 1'b0;
      conv_last     <= 1'b0;
      idx           <= '0;
      len           <= '0;
      bval          <= '0;
      for (int unsigned j = 1; j <= K; j++) begin
        best[j] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          s_axis_tready <= 1'b1;
          if (beat_acc) begin
            if (eob) begin
              // Snapshot the result including this beat's digit, then start the next bank clean.
              conv_bcd      <= best_nx[K];
              conv_ok       <= bval_nx[K];
              conv_last     <= s_axis_tlast;
              idx           <= '0;
              acc           <= '0;
              len           <= '0;
              bval          <= '0;
              for (int unsigned j = 1; j <= K; j++) begin
                best[j] <= '0;
              end
              s_axis_tready <= 1'b0;
              state         <= S_CONV;
            end else begin
              bval <= bval_nx;
              for (int unsigned j = 1; j <= K; j++) begin
                best[j] <= best_nx[j];
              end
              if (dig_ok && len != 5'(K)) begin
                len <= len + 5'd1;
              end
            end
          end
        end
        S_CONV: begin
          acc      <= acc_nx;
          conv_bcd <= conv_bcd << 4;
          idx      <= idx + 5'd1;
          if (idx == 5'(K - 1)) begin
            if (conv_ok) begin
              sum <= sum + acc_nx;
            end
            if (conv_last) begin
              state         <= S_OUTPUT;
              m_axis_tvalid <= 1'b1;
            end else begin
              state         <= S_IDLE;
              s_axis_tready <= 1'b1;
            end
          end
        end
        S_OUTPUT: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            sum           <= '0;
            state         <= S_IDLE;
            s_axis_tready <= 1'b1;
          end
        end
        default: begin
          state         <= S_IDLE;
          s_axis_tready <= 1'b0;
        end
      endcase
    end
  end

`ifdef DAY3_TOPK_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_count       <= '0;
      short_bank_count <= '0;
    end else if (state == S_OUTPUT && m_axis_tready) begin
      bank_count       <= '0;
      short_bank_count <= '0;
    end else if (state == S_IDLE && beat_acc && eob) begin
      if (bank_count != '1) begin
        bank_count <= bank_count + 32'd1;
      end
      if (!bval_nx[K] && short_bank_count != '1) begin
        short_bank_count <= short_bank_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_day_3_topk.sv
// Directed bench for day_3_topk: a K=2 and a K=12 instance driven from a table of digit files.
module tb_day_3_topk;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  tdata = '0;
  logic        tuser = 1'b0;
  logic        tlast = 1'b0;
  logic        tv2 = 1'b0, tv12 = 1'b0;
  logic        mr2 = 1'b0, mr12 = 1'b0;
  logic        rdy2, rdy12, mv2, mv12, ml2, ml12;
  logic [63:0] md2, md12;
`ifdef DAY3_TOPK_STATS_EN
  logic [31:0] bc2, bc12, sc2, sc12;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  day_3_topk #(.K(2), .OUTPUTWIDTH(64)) u_k2 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(tv2), .s_axis_tready(rdy2), .s_axis_tdata(tdata),
    .s_axis_tuser(tuser), .s_axis_tlast(tlast),
    .m_axis_tvalid(mv2), .m_axis_tready(mr2), .m_axis_tdata(md2), .m_axis_tlast(ml2)
`ifdef DAY3_TOPK_STATS_EN
    , .bank_count(bc2), .short_bank_count(sc2)
`endif
  );

  day_3_topk #(.K(12), .OUTPUTWIDTH(64)) u_k12 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(tv12), .s_axis_tready(rdy12), .s_axis_tdata(tdata),
    .s_axis_tuser(tuser), .s_axis_tlast(tlast),
    .m_axis_tvalid(mv12), .m_axis_tready(mr12), .m_axis_tdata(md12), .m_axis_tlast(ml12)
`ifdef DAY3_TOPK_STATS_EN
    , .bank_count(bc12), .short_bank_count(sc12)
`endif
  );

  typedef struct {
    int          sel;   // 0: K=2 instance, 1: K=12 instance
    string       s;     // digits, '/' ends a bank, a-f are non-digit nibbles; last char carries tlast
    logic [63:0] exp;
    int          hold;  // cycles m_axis_tready stays low before accepting
  } vec_t;

  function automatic logic get_rdy(int sel); return sel != 0 ? rdy12 : rdy2; endfunction
  function automatic logic get_mv(int sel);  return sel != 0 ? mv12 : mv2;   endfunction
  function automatic logic get_ml(int sel);  return sel != 0 ? ml12 : ml2;   endfunction
  function automatic logic [63:0] get_md(int sel); return sel != 0 ? md12 : md2; endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_mr(input int sel, input logic v);
    if (sel != 0) mr12 = v; else mr2 = v;
  endtask

  // Entered and left at a negedge with tvalid low.
  task automatic send_beat(input int sel, input logic [3:0] d, input logic u, input logic l);
    int n = 0;
    while (!get_rdy(sel) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("tready_timeout", 0, 1);
    tdata = d; tuser = u; tlast = l;
    if (sel != 0) tv12 = 1'b1; else tv2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tv2 = 1'b0; tv12 = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  task automatic wait_mv(input int sel, input int kk);
    int n = 0;
    while (!get_mv(sel) && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("conv_cycles", n, kk);
  endtask

  task automatic run_file(input int sel, input string s, input logic [63:0] exp, input int hold);
    int kk = (sel != 0) ? 12 : 2;
    int last = -1;
    int nvalid = 0, nbanks = 0, nshort = 0, bad = 0, n;
    byte c;
    logic [3:0] d;
    logic u, l;
    for (int i = 0; i < s.len(); i++) if (s[i] != "/") last = i;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == "/") continue;
      d = (c >= "a") ? 4'(c - "a" + 10) : 4'(c - "0");
      u = (i + 1 < s.len()) && (s[i+1] == "/");
      l = (i == last);
      if (d <= 4'd9) nvalid++;
      send_beat(sel, d, u, l);
      if (u || l) begin
        nbanks++;
        if (nvalid < kk) nshort++;
        nvalid = 0;
        if (!l) begin
          n = 0;
          while (!get_rdy(sel) && n < 200) begin
            n++;
            @(negedge clk);
          end
          check("tready_gap", n, kk);
        end
      end
    end
    wait_mv(sel, kk);
    check("out_valid", get_mv(sel), 1);
    check("out_last", get_ml(sel), 1);
    check({"out_sum ", s}, get_md(sel), exp);
`ifdef DAY3_TOPK_STATS_EN
    check("bank_count", sel != 0 ? bc12 : bc2, nbanks);
    check("short_bank_count", sel != 0 ? sc12 : sc2, nshort);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (get_mv(sel) !== 1'b1 || get_md(sel) !== exp || get_rdy(sel) !== 1'b0) bad++;
    end
    if (hold > 0) check("stall_stable", bad, 0);
    set_mr(sel, 1'b1);
    @(negedge clk);
    set_mr(sel, 1'b0);
    check("post_hs_valid", get_mv(sel), 0);
    check("post_hs_sum", get_md(sel), 0);
    check("post_hs_ready", get_rdy(sel), 1);
`ifdef DAY3_TOPK_STATS_EN
    check("post_hs_bank_count", sel != 0 ? bc12 : bc2, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    vecs[0] = '{0, "987654321111111/811111111111119/234234234234278/818181911112111", 64'd357, 20};
    vecs[1] = '{1, "987654321111111/811111111111119/234234234234278/818181911112111", 64'd3121910778619, 0};
    vecs[2] = '{0, "5/91", 64'd91, 0};
    vecs[3] = '{0, "1a9", 64'd19, 3};
    vecs[4] = '{0, "0/00", 64'd0, 0};
    vecs[5] = '{0, "34/f", 64'd34, 0};
    vecs[6] = '{0, "21/", 64'd21, 0};
    vecs[7] = '{0, "19/99/55", 64'd173, 0};
    vecs[8] = '{1, "111111111111/12345", 64'd111111111111, 0};
    vecs[9] = '{1, "9f8765432109870", 64'd987654329870, 2};

    @(negedge clk);
    check("rst_tready", rdy2, 0);
    check("rst_tvalid", mv2, 0);
    check("rst_tdata", md2, 0);
    rst = 1'b0;
    @(negedge clk);
    check("first_tready", rdy2, 1);

    foreach (vecs[i]) run_file(vecs[i].sel, vecs[i].s, vecs[i].exp, vecs[i].hold);

    // Reset while the sum is waiting for acceptance: it must vanish without a clock edge.
    send_beat(0, 4'd9, 1'b0, 1'b0);
    send_beat(0, 4'd8, 1'b0, 1'b1);
    wait_mv(0, 2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tvalid", mv2, 0);
    check("async_rst_tdata", md2, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_ready", rdy2, 1);
    check("rst_out_valid", mv2, 0);

    // Reset mid-bank: the 9,8 prefix must not leak into the next file.
    send_beat(0, 4'd9, 1'b0, 1'b0);
    send_beat(0, 4'd8, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tready", rdy2, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    run_file(0, "12", 64'd12, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/day_3_topk.md
Name: day_3_topk

Overview:
- Streaming successor to the day-3 battery-bank solver, generalised from a fixed 2-digit pick to a parametrised K-digit pick.
- Receives banks as a stream of decimal digits, one digit per AXI4-Stream beat. For each bank it finds the largest K-digit number formed by keeping K digits in their original order.
- Converts each bank result to binary and accumulates it. Emits the grand total on the master stream after the final bank (tlast).

Parameters:
- K, default 12: digits selected per bank; valid range 1..16.
- OUTPUTWIDTH, default 64: sum width; must be >= ceil(K*log2(10)) (40 for K=12).

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_axis_tvalid  input  1  digit beat valid.
- s_axis_tready  output  1  block can accept a digit beat.
- s_axis_tdata  input  4  one digit, binary 0..9.
- s_axis_tuser  input  1  this beat is the last digit of a bank.
- s_axis_tlast  input  1  this beat is the last digit of the last bank; implies end-of-bank.
- m_axis_tvalid  output  1  sum valid.
- m_axis_tready  input  1  downstream accepts the sum.
- m_axis_tdata  output  OUTPUTWIDTH  accumulated sum.
- m_axis_tlast  output  1  equals m_axis_tvalid; one-beat packet.

Behaviour:
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, sum=0, all best[] cleared, state=S_IDLE. On the first clk edge after rst deasserts, tready=1.
- Reset mid-bank or mid-output: all progress is discarded; nothing is emitted.
- State S_IDLE: tready=1. On handshake with digit d:
  - If d>9, the digit is ignored but the tuser/tlast flags still take effect.
  - Otherwise, for all j=1..K in parallel: best[j] <= max(best[j], best[j-1] concatenated with d). best[0] is the empty string.
  - best[j] is a j-digit BCD vector with a valid bit; candidates are compared lexicographically.
  - A candidate whose best[j-1] is invalid (j>1) is not considered.
  - The len counter saturates at K.
- End-of-bank (tuser or tlast on an accepted beat): that beat's digit is included, then S_CONV is entered with a copy of best[K] and a digit index of 0.
- State S_CONV: tready=0. Runs exactly K cycles.
  - Each cycle: acc <= acc*10 + next digit of best[K], most-significant digit first.
  - Last cycle: sum <= sum + acc, modulo 2^OUTPUTWIDTH. This happens only if best[K] is valid; a bank with fewer than K valid digits adds 0.
  - best[] and len are cleared.
  - Next state: S_OUTPUT if the bank ended with tlast, else S_IDLE.
- Throughput: an end-of-bank beat accepted at cycle t gives tready=1 again at cycle t+K+1.
- State S_OUTPUT: m_axis_tvalid=1, m_axis_tdata=sum, both held stable until m_axis_tready.
  - On the output handshake: tvalid=0 and sum=0 on the next cycle, and the state returns to S_IDLE.
  - tready stays 0 throughout S_OUTPUT.
- Boundary cases:
  - tuser and tlast together behave as tlast.
  - tlast with no digits since the previous bank adds 0 and still emits the sum.
  - Digit 0 is a legal digit.
  - Equal candidates keep the existing value (no update needed).

Optional Feature:
- Macro DAY3_TOPK_STATS_EN.
- Defined: adds output ports bank_count [31:0] and short_bank_count [31:0].
  - bank_count increments on every end-of-bank.
  - short_bank_count increments when best[K] is invalid at end-of-bank.
  - Both are cleared by rst and by the output handshake, and both saturate at all-ones.
- Undefined: neither the ports nor the logic exist; all other behaviour is identical.

Test Plan:
- K=2, four banks 987654321111111 / 811111111111119 / 234234234234278 / 818181911112111 with tlast on the last digit -> single output 357. tready is low for exactly 2 cycles after each end-of-bank.
- K=12, same four banks -> 3121910778619; S_CONV lasts exactly 12 cycles per bank.
- K=2, banks "5" then "91" (tlast) -> 91. With DAY3_TOPK_STATS_EN: bank_count=2, short_bank_count=1.
- K=2, bank "1a9" with nibble 0xA in the middle (tlast) -> 19; the invalid digit is skipped.
- K=2, m_axis_tready held low 20 cycles -> tvalid=1 and tdata stable throughout; after the handshake the next file starts from sum=0.
- K=2, rst pulsed mid-bank after digits 9,8 (async, between edges) -> tvalid=0 immediately. The subsequent bank 12 (tlast) -> 12, with no residue from before the reset.
